// File: rtl/axi_lite_uart_rx_if.sv
// AXI4-Lite read-channel bundle for the UART receive half of the axi_lite2uart bridge.
// The host drives through the master modport; axi_lite_uart_rx uses the slave modport.
interface axi_lite_uart_rx_if #(
  parameter int AXI_ADDR_WIDTH = 4,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_RESP_WIDTH = 2
);
  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr;
  logic                      s_axi_arvalid;
  logic                      s_axi_arready;
  logic [AXI_DATA_WIDTH-1:0] s_axi_rdata;
  logic [AXI_RESP_WIDTH-1:0] s_axi_rresp;
  logic                      s_axi_rvalid;
  logic                      s_axi_rready;

  modport master (
    output s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

  modport slave (
    input  s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );
endinterface

// File: rtl/axi_lite_uart_rx.sv
// AXI4-Lite read-only slave with UART receiver and RX FIFO; registers RXDATA (0x0) and STATUS (0x4).
// Optional even-parity bit per frame when UART_RX_PARITY_EN is defined.
module axi_lite_uart_rx #(
  parameter int AXI_ADDR_WIDTH = 4,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_RESP_WIDTH = 2,
  parameter int CLKS_PER_BIT   = 868,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                uart_rxd,
  axi_lite_uart_rx_if.slave   s_axi,
  output logic                uart_irq
);

`ifdef UART_RX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif
  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FILL_W = PTR_W + 1;
  localparam int HALF   = CLKS_PER_BIT / 2;

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} rx_state_t;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

  rx_state_t                 state_r, state_s;
  logic [CNT_W-1:0]          cnt_r, cnt_s;
  logic [2:0]                bit_idx_r, bit_idx_s;
  logic [7:0]                shift_r, shift_s;
  logic                      par_bad_r, par_bad_s;
  logic                      rxd_meta_r, rxd_sync_r;
  logic                      push_s, frame_set_s, par_set_s, bit_end_s;
  logic [7:0]                mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr_r, rd_ptr_r;
  logic [FILL_W-1:0]         fill_r;
  logic                      ovr_r, frame_r, par_r;
  logic                      full_s, empty_s, accept_s, pop_s, wr_en_s, ovr_set_s, stat_rd_s;
  logic [1:0]                sel_s;
  logic [AXI_DATA_WIDTH-1:0] rd_data_s, rdata_r;
  logic [AXI_RESP_WIDTH-1:0] rd_resp_s, rresp_r;
  logic                      arready_r, rvalid_r, irq_r;
  logic [AXI_ADDR_WIDTH-1:0] addr_unused_s;

  assign addr_unused_s = s_axi.s_axi_araddr;
  assign sel_s         = s_axi.s_axi_araddr[3:2];

  // two-flop synchroniser for the asynchronous serial line
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta_r <= 1'b1;
      rxd_sync_r <= 1'b1;
    end else begin
      rxd_meta_r <= uart_rxd;
      rxd_sync_r <= rxd_meta_r;
    end
  end

  // receiver state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'd0;
      par_bad_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      bit_idx_r <= bit_idx_s;
      shift_r   <= shift_s;
      par_bad_r <= par_bad_s;
    end
  end

  // receiver next state: start bit checked at half period, later bits one full period apart
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r + CNT_W'(1);
    bit_idx_s   = bit_idx_r;
    shift_s     = shift_r;
    par_bad_s   = par_bad_r;
    push_s      = 1'b0;
    frame_set_s = 1'b0;
    par_set_s   = 1'b0;
    bit_end_s   = (cnt_r == CNT_W'(CLKS_PER_BIT - 1));
    case (state_r)
      ST_IDLE: begin
        cnt_s = '0;
        if (!rxd_sync_r) state_s = ST_START;
        else             state_s = ST_IDLE;
      end
      ST_START: begin
        if (cnt_r == CNT_W'(HALF - 1)) begin
          cnt_s     = '0;
          bit_idx_s = 3'd0;
          par_bad_s = 1'b0;
          if (rxd_sync_r) state_s = ST_IDLE;
          else            state_s = ST_DATA;
        end else begin
          state_s = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          cnt_s     = '0;
          shift_s   = {rxd_sync_r, shift_r[7:1]};
          bit_idx_s = bit_idx_r + 3'd1;
          if (bit_idx_r == 3'd7) state_s = PARITY_EN ? ST_PARITY : ST_STOP;
          else                   state_s = ST_DATA;
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          cnt_s     = '0;
          par_bad_s = (rxd_sync_r != even_parity(shift_r));
          state_s   = ST_STOP;
        end else begin
          state_s = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          cnt_s   = '0;
          state_s = ST_IDLE;
          if (!rxd_sync_r)    frame_set_s = 1'b1;
          else if (par_bad_r) par_set_s   = 1'b1;
          else                push_s      = 1'b1;
        end else begin
          state_s = ST_STOP;
        end
      end
      default: begin
        cnt_s   = '0;
        state_s = ST_IDLE;
      end
    endcase
  end

  assign full_s    = (fill_r == FILL_W'(FIFO_DEPTH));
  assign empty_s   = (fill_r == FILL_W'(0));
  assign accept_s  = s_axi.s_axi_arvalid && arready_r;
  assign pop_s     = accept_s && (sel_s == 2'd0) && !empty_s;
  assign stat_rd_s = accept_s && (sel_s == 2'd1);
  // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign wr_en_s   = push_s && (!full_s || pop_s);
  assign ovr_set_s = push_s && full_s && !pop_s;

  // FIFO storage
  always_ff @(posedge clk) begin
    if (wr_en_s) mem_r[wr_ptr_r] <= shift_r;
  end

  // FIFO pointers and fill level
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      fill_r   <= '0;
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)   rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({wr_en_s, pop_s})
        2'b10:   fill_r <= fill_r + FILL_W'(1);
        2'b01:   fill_r <= fill_r - FILL_W'(1);
        default: fill_r <= fill_r;
      endcase
    end
  end

  // sticky error flags; a new event wins over a same-cycle STATUS clear
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_r   <= 1'b0;
      frame_r <= 1'b0;
      par_r   <= 1'b0;
    end else begin
      if (ovr_set_s)      ovr_r <= 1'b1;
      else if (stat_rd_s) ovr_r <= 1'b0;
      if (frame_set_s)    frame_r <= 1'b1;
      else if (stat_rd_s) frame_r <= 1'b0;
      if (par_set_s)      par_r <= 1'b1;
      else if (stat_rd_s) par_r <= 1'b0;
    end
  end

  // register read mux
  always_comb begin
    rd_data_s = '0;
    rd_resp_s = '0;
    case (sel_s)
      2'd0: begin
        if (!empty_s) begin
          rd_data_s[31]  = 1'b1;
          rd_data_s[7:0] = mem_r[rd_ptr_r];
        end else begin
          rd_data_s = '0;
        end
      end
      2'd1: begin
        rd_data_s[0]           = !empty_s;
        rd_data_s[1]           = full_s;
        rd_data_s[2]           = ovr_r;
        rd_data_s[3]           = frame_r;
        rd_data_s[4]           = par_r;
        rd_data_s[8 +: FILL_W] = fill_r;
      end
      default: rd_resp_s = AXI_RESP_WIDTH'(2'b10);
    endcase
  end

  // AXI read channel and interrupt
  always_ff @(posedge clk) begin
    if (rst) begin
      arready_r <= 1'b1;
      rvalid_r  <= 1'b0;
      rdata_r   <= '0;
      rresp_r   <= '0;
      irq_r     <= 1'b0;
    end else begin
      if (accept_s) begin
        arready_r <= 1'b0;
        rvalid_r  <= 1'b1;
        rdata_r   <= rd_data_s;
        rresp_r   <= rd_resp_s;
      end else if (rvalid_r && s_axi.s_axi_rready) begin
        arready_r <= 1'b1;
        rvalid_r  <= 1'b0;
      end
      irq_r <= !empty_s || ovr_r;
    end
  end

  assign s_axi.s_axi_arready = arready_r;
  assign s_axi.s_axi_rvalid  = rvalid_r;
  assign s_axi.s_axi_rdata   = rdata_r;
  assign s_axi.s_axi_rresp   = rresp_r;
  assign uart_irq            = irq_r;

endmodule

// File: tb/tb_axi_lite_uart_rx.sv
// Bench for axi_lite_uart_rx: vector table, directed corner cases, and random traffic
// checked against a queue-based model of the register map.
module tb_axi_lite_uart_rx;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst;
  logic uart_rxd;
  logic irq;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] mq[$];
  logic       m_ovr = 1'b0;
  logic       m_frame = 1'b0;

  axi_lite_uart_rx_if #(.AXI_ADDR_WIDTH(4), .AXI_DATA_WIDTH(32), .AXI_RESP_WIDTH(2)) bus ();

  axi_lite_uart_rx #(
    .AXI_ADDR_WIDTH(4), .AXI_DATA_WIDTH(32), .AXI_RESP_WIDTH(2),
    .CLKS_PER_BIT(CPB), .FIFO_DEPTH(16)
  ) dut (
    .clk(clk), .rst(rst), .uart_rxd(uart_rxd), .s_axi(bus.slave), .uart_irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    bit          send;
    logic [7:0]  tx;
    logic [3:0]  addr;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic bit_time(input logic v);
    uart_rxd = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
`ifdef UART_RX_PARITY_EN
    bit_time(^b);
`endif
    bit_time(stop);
    uart_rxd = 1'b1;
    if (stop) begin
      if (mq.size() < 16) mq.push_back(b);
      else                m_ovr = 1'b1;
    end else begin
      m_frame = 1'b1;
      repeat (20) @(posedge clk);
      #1;
    end
  endtask

  task automatic model_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] r);
    logic [7:0] b;
    d = 32'd0;
    r = 2'b00;
    case (a[3:2])
      2'd0: if (mq.size() > 0) begin
        b = mq.pop_front();
        d = {1'b1, 23'd0, b};
      end
      2'd1: begin
        d[12:8] = 5'(mq.size());
        d[0]    = (mq.size() > 0);
        d[1]    = (mq.size() == 16);
        d[2]    = m_ovr;
        d[3]    = m_frame;
        m_ovr   = 1'b0;
        m_frame = 1'b0;
      end
      default: r = 2'b10;
    endcase
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] r);
    int t;
    bus.s_axi_araddr  = a;
    bus.s_axi_arvalid = 1'b1;
    bus.s_axi_rready  = 1'b1;
    t = 0;
    while (!bus.s_axi_arready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    @(posedge clk); #1;
    bus.s_axi_arvalid = 1'b0;
    t = 0;
    while (!bus.s_axi_rvalid && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (!bus.s_axi_rvalid) begin
      checks++; errors++;
      $display("FAIL rvalid_timeout: got 0 expected 1");
    end
    d = bus.s_axi_rdata;
    r = bus.s_axi_rresp;
    @(posedge clk); #1;
  endtask

  task automatic rd_check(input logic [3:0] a, input string nm);
    logic [31:0] d, ed;
    logic [1:0]  r, er;
    axi_read(a, d, r);
    model_read(a, ed, er);
    check({nm, "_data"}, d, ed);
    check({nm, "_resp"}, {30'd0, r}, {30'd0, er});
  endtask

  task automatic irq_check(input string nm);
    check(nm, {31'd0, irq}, {31'd0, (mq.size() > 0) || m_ovr});
  endtask

  initial begin
    logic [31:0] d, ed;
    logic [1:0]  r, er;
    logic [3:0]  ra;
    int          op;

    vecs[0] = '{1'b0, 8'h00, 4'h4, 32'h0000_0000, 2'b00, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 4'h0, 32'h0000_0000, 2'b00, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 4'h8, 32'h0000_0000, 2'b10, 1'b0};
    vecs[3] = '{1'b0, 8'h00, 4'hC, 32'h0000_0000, 2'b10, 1'b0};
    vecs[4] = '{1'b1, 8'hA5, 4'h4, 32'h0000_0101, 2'b00, 1'b1};
    vecs[5] = '{1'b0, 8'h00, 4'h0, 32'h8000_00A5, 2'b00, 1'b1};
    vecs[6] = '{1'b0, 8'h00, 4'h0, 32'h0000_0000, 2'b00, 1'b0};

    rst = 1'b1;
    uart_rxd = 1'b1;
    bus.s_axi_araddr  = 4'h0;
    bus.s_axi_arvalid = 1'b0;
    bus.s_axi_rready  = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_arready", {31'd0, bus.s_axi_arready}, 32'd1);
    check("rst_rvalid", {31'd0, bus.s_axi_rvalid}, 32'd0);
    check("rst_rdata", bus.s_axi_rdata, 32'd0);
    check("rst_rresp", {30'd0, bus.s_axi_rresp}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].send) send_frame(vecs[i].tx, 1'b1);
      check($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
      axi_read(vecs[i].addr, d, r);
      model_read(vecs[i].addr, ed, er);
      check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
      check($sformatf("vec%0d_resp", i), {30'd0, r}, {30'd0, vecs[i].exp_resp});
    end

    // 17 bytes without reads: FIFO fills, last byte overruns
    for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1);
    irq_check("fill_irq");
    axi_read(4'h4, d, r);
    model_read(4'h4, ed, er);
    check("full_status", d, 32'h0000_1007);
    rd_check(4'h4, "full_status2");
    for (int i = 0; i < 16; i++) rd_check(4'h0, $sformatf("drain%0d", i));
    rd_check(4'h0, "drain_empty");
    irq_check("drain_irq");

    // bad stop bit
    send_frame(8'h3C, 1'b0);
    axi_read(4'h4, d, r);
    model_read(4'h4, ed, er);
    check("frame_status", d, 32'h0000_0008);
    rd_check(4'h4, "frame_status2");

    // SLVERR read with rready held low
    bus.s_axi_araddr  = 4'h8;
    bus.s_axi_arvalid = 1'b1;
    bus.s_axi_rready  = 1'b0;
    @(posedge clk); #1;
    bus.s_axi_arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_rvalid", {31'd0, bus.s_axi_rvalid}, 32'd1);
      check("stall_arready", {31'd0, bus.s_axi_arready}, 32'd0);
      check("stall_rdata", bus.s_axi_rdata, 32'd0);
      check("stall_rresp", {30'd0, bus.s_axi_rresp}, 32'd2);
      @(posedge clk); #1;
    end
    bus.s_axi_rready = 1'b1;
    @(posedge clk); #1;
    check("stall_done_rvalid", {31'd0, bus.s_axi_rvalid}, 32'd0);
    check("stall_done_arready", {31'd0, bus.s_axi_arready}, 32'd1);

    // short low glitch then a genuine frame
    uart_rxd = 1'b0;
    repeat (8) @(posedge clk);
    #1 uart_rxd = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    rd_check(4'h4, "glitch_status");
    send_frame(8'h5A, 1'b1);
    rd_check(4'h0, "after_glitch");

    // random traffic against the model
    for (int n = 0; n < 50; n++) begin
      op = int'($urandom_range(0, 3));
      if (op <= 1) begin
        send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 7) != 0));
      end else if (op == 2) begin
        rd_check(4'h0, "rnd_rxdata");
      end else begin
        ra = 4'($urandom_range(0, 15));
        rd_check(ra, "rnd_read");
      end
      irq_check("rnd_irq");
    end

    // reset in the middle of a frame with data already queued
    send_frame(8'h11, 1'b1);
    uart_rxd = 1'b0;
    repeat (50) @(posedge clk);
    #1 rst = 1'b1;
    uart_rxd = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mq.delete();
    m_ovr = 1'b0;
    m_frame = 1'b0;
    check("rst2_arready", {31'd0, bus.s_axi_arready}, 32'd1);
    check("rst2_rvalid", {31'd0, bus.s_axi_rvalid}, 32'd0);
    check("rst2_irq", {31'd0, irq}, 32'd0);
    rd_check(4'h4, "rst2_status");
    send_frame(8'hC3, 1'b1);
    rd_check(4'h0, "rst2_rxdata");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
